led_pattern_sequencer: RTL and testbench

Pattern controller for the 8-LED running-light board. It owns the step prescaler and sequences four LED patterns: rotate-left pair, rotate-right pair, bouncing pair and fill/drain. Mode changes arrive as requests and are applied only on the next step tick, so the pattern always restarts cleanly. It replaces the free-running 2-LED chaser at the top level and drives `led[7:0]` directly.

---
 rtl/led_pattern_sequencer.sv | 127 ++++++++++++
 tb/tb_led_pattern_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_sequencer.sv
// Prescaled 8-LED pattern engine: four patterns, mode changes applied on the next step tick.
// Build option: define LED_SEQ_AUTO_EN to advance to the next mode at each frame end.
module led_pattern_sequencer #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       rs,
  input  logic [1:0] mode_req,
  input  logic       mode_load,
  input  logic       pause,
  output logic [7:0] led,
  output logic [1:0] mode,
  output logic       pending,
  output logic       step_tick,
  output logic       frame_done
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    ROT_L  = 2'd0,
    ROT_R  = 2'd1,
    BOUNCE = 2'd2,
    FILL   = 2'd3
  } mode_t;

  logic [CNT_W-1:0] cnt;
  logic [3:0]       step;
  mode_t            mode_q;
  mode_t            pend_mode;
  logic             dir;
  logic             tick;
  logic [7:0]       led_next;
  logic             dir_next;

  function automatic logic [7:0] init_led(input mode_t m);
    case (m)
      ROT_R:   init_led = 8'hC0;
      FILL:    init_led = 8'h00;
      default: init_led = 8'h03;
    endcase
  endfunction

  function automatic logic [3:0] last_step(input mode_t m);
    case (m)
      BOUNCE:  last_step = 4'd11;
      FILL:    last_step = 4'd15;
      default: last_step = 4'd7;
    endcase
  endfunction

  assign tick = (cnt == CNT_LAST) && !pause;
  assign mode = mode_q;

  // Next pattern value; bounce direction flips when the pair reaches either end.
  always_comb begin
    led_next = led;
    dir_next = dir;
    case (mode_q)
      ROT_L: led_next = {led[6:0], led[7]};
      ROT_R: led_next = {led[0], led[7:1]};
      BOUNCE: begin
        led_next = dir ? {1'b0, led[7:1]} : {led[6:0], 1'b0};
        if (led_next == 8'hC0)
          dir_next = 1'b1;
        else if (led_next == 8'h03)
          dir_next = 1'b0;
      end
      FILL: led_next = (step < 4'd8) ? {led[6:0], 1'b1} : {1'b0, led[7:1]};
    endcase
  end

`ifdef LED_SEQ_AUTO_EN
  mode_t mode_succ;
  assign mode_succ = mode_t'(2'(mode_q + 2'd1));
`endif

  always_ff @(posedge clk or posedge rs) begin
    if (rs) begin
      cnt        <= '0;
      step       <= 4'd0;
      mode_q     <= ROT_L;
      pend_mode  <= ROT_L;
      pending    <= 1'b0;
      dir        <= 1'b0;
      led        <= 8'h03;
      step_tick  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      step_tick  <= tick;
      frame_done <= 1'b0;
      if (!pause)
        cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
      if (mode_load) begin
        pending   <= 1'b1;
        pend_mode <= mode_t'(mode_req);
      end
      // A tick acts on the request stored before this edge; a same-cycle load stays pending.
      if (tick) begin
        if (pending) begin
          mode_q <= pend_mode;
          led    <= init_led(pend_mode);
          step   <= 4'd0;
          dir    <= 1'b0;
          if (!mode_load)
            pending <= 1'b0;
        end else if (step == last_step(mode_q)) begin
          step       <= 4'd0;
          dir        <= 1'b0;
          frame_done <= 1'b1;
`ifdef LED_SEQ_AUTO_EN
          mode_q <= mode_succ;
          led    <= init_led(mode_succ);
`else
          led    <= init_led(mode_q);
`endif
        end else begin
          step <= step + 1'b1;
          led  <= led_next;
          dir  <= dir_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Scoreboard bench for led_pattern_sequencer: table-driven pattern model, randomized requests and pauses.
`timescale 1ns/1ps
module tb_led_pattern_sequencer;
  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rs = 1'b1;
  logic [1:0] mode_req = 2'd0;
  logic       mode_load = 1'b0;
  logic       pause = 1'b0;
  logic [7:0] led;
  logic [1:0] mode;
  logic       pending;
  logic       step_tick;
  logic       frame_done;

  led_pattern_sequencer #(.TICK_DIV(TD)) dut (
    .clk(clk), .rs(rs), .mode_req(mode_req), .mode_load(mode_load), .pause(pause),
    .led(led), .mode(mode), .pending(pending), .step_tick(step_tick), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int         cyc;
    logic [7:0] led;
    logic [1:0] mode;
    logic       pend;
    logic       fd;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass = 0;
  int   ncyc = 0;
  int   n_ticks = 0;

  // Reference model state: prescaler count, step index, modes and pending flag.
  int m_cnt, m_step, m_mode, m_pmode;
  bit m_pend;

  logic [7:0] rl_tab [8]  = '{8'h03, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'h81};
  logic [7:0] rr_tab [8]  = '{8'hC0, 8'h60, 8'h30, 8'h18, 8'h0C, 8'h06, 8'h03, 8'h81};
  logic [7:0] bo_tab [12] = '{8'h03, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60,
                              8'hC0, 8'h60, 8'h30, 8'h18, 8'h0C, 8'h06};

  function automatic int per(input int m);
    case (m)
      2:       return 12;
      3:       return 16;
      default: return 8;
    endcase
  endfunction

  function automatic logic [7:0] pat(input int m, input int s);
    case (m)
      0:       return rl_tab[s[2:0]];
      1:       return rr_tab[s[2:0]];
      2:       return bo_tab[s[3:0]];
      default: return (s <= 8) ? 8'((1 << s) - 1) : 8'(8'hFF >> (s - 8));
    endcase
  endfunction

  task automatic check(input string name, input bit ok, input string got, input string want);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %s, expected %s", name, got, want);
  endtask

  task automatic model_reset();
    m_cnt = 0; m_step = 0; m_mode = 0; m_pmode = 0; m_pend = 0;
    exp_q.delete();
  endtask

  // Drive one cycle of inputs, advance the model on the edge, queue the expected step result.
  task automatic cycle(input logic [1:0] req, input logic ld, input logic pz);
    bit tk, fd;
    mode_req = req; mode_load = ld; pause = pz;
    @(posedge clk);
    ncyc++;
    tk = (m_cnt == TD - 1) && !pz;
    if (!pz) m_cnt = (m_cnt == TD - 1) ? 0 : m_cnt + 1;
    fd = 0;
    if (tk) begin
      if (m_pend) begin
        m_mode = m_pmode; m_step = 0; m_pend = 0;
      end else if (m_step == per(m_mode) - 1) begin
        m_step = 0; fd = 1;
`ifdef LED_SEQ_AUTO_EN
        m_mode = (m_mode + 1) % 4;
`endif
      end else begin
        m_step++;
      end
    end
    if (ld) begin m_pend = 1; m_pmode = int'(req); end
    if (tk) exp_q.push_back('{ncyc, pat(m_mode, m_step), 2'(m_mode), m_pend, fd});
    #1;
  endtask

  always @(negedge clk) begin
    if (!rs) begin
      if (step_tick) begin
        n_ticks++;
        if (exp_q.size() == 0) begin
          check("unexpected_tick", 1'b0, $sformatf("tick cyc=%0d led=%h", ncyc, led), "no tick");
        end else begin
          mon_e = exp_q.pop_front();
          check("step", (mon_e.cyc == ncyc) && (led === mon_e.led) && (mode === mon_e.mode) &&
                (pending === mon_e.pend) && (frame_done === mon_e.fd),
                $sformatf("cyc=%0d led=%h mode=%0d pend=%b fd=%b", ncyc, led, mode, pending, frame_done),
                $sformatf("cyc=%0d led=%h mode=%0d pend=%b fd=%b", mon_e.cyc, mon_e.led, mon_e.mode, mon_e.pend, mon_e.fd));
        end
      end else begin
        check("fd_without_tick", frame_done === 1'b0, $sformatf("%b", frame_done), "0");
      end
    end
  end

  initial begin
    logic [7:0] saved;
    int         t0;

    // Power-on reset
    rs = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    check("rst_led", led === 8'h03, $sformatf("%h", led), "03");
    check("rst_mode", mode === 2'd0, $sformatf("%0d", mode), "0");
    check("rst_pending", pending === 1'b0, $sformatf("%b", pending), "0");
    check("rst_step_tick", step_tick === 1'b0, $sformatf("%b", step_tick), "0");
    check("rst_frame_done", frame_done === 1'b0, $sformatf("%b", frame_done), "0");
    rs = 1'b0;

    // ROT_L full frame
    repeat (8 * TD + 2) cycle(2'd0, 1'b0, 1'b0);

    // BOUNCE request mid-interval
    cycle(2'd2, 1'b1, 1'b0);
    check("load_pending", pending === 1'(m_pend), $sformatf("%b", pending), $sformatf("%b", m_pend));
    repeat (14 * TD) cycle(2'd0, 1'b0, 1'b0);

    // FILL full/empty
    cycle(2'd3, 1'b1, 1'b0);
    repeat (18 * TD) cycle(2'd0, 1'b0, 1'b0);

    // Back to ROT_L, then collide a load with a tick
    cycle(2'd0, 1'b1, 1'b0);
    repeat (2 * TD) cycle(2'd0, 1'b0, 1'b0);
    for (int i = 0; i < TD && m_cnt != TD - 1; i++) cycle(2'd0, 1'b0, 1'b0);
    cycle(2'd1, 1'b1, 1'b0);
    check("collision_state", (pending === 1'(m_pend)) && (mode === 2'(m_mode)),
          $sformatf("pend=%b mode=%0d", pending, mode), $sformatf("pend=%b mode=%0d", m_pend, m_mode));
    repeat (2 * TD) cycle(2'd0, 1'b0, 1'b0);

    // Overwrite: 1 then 3 before the tick
    for (int i = 0; i < TD && m_cnt != 0; i++) cycle(2'd0, 1'b0, 1'b0);
    cycle(2'd1, 1'b1, 1'b0);
    cycle(2'd3, 1'b1, 1'b0);
    repeat (3 * TD) cycle(2'd0, 1'b0, 1'b0);
    check("overwrite_mode", mode === 2'(m_mode), $sformatf("%0d", mode), $sformatf("%0d", m_mode));

    // Pause for 10 cycles with a load inside
    cycle(2'd0, 1'b0, 1'b0);
    saved = led;
    t0 = n_ticks;
    repeat (4) cycle(2'd0, 1'b0, 1'b1);
    cycle(2'd2, 1'b1, 1'b1);
    repeat (5) cycle(2'd0, 1'b0, 1'b1);
    check("pause_led", led === saved, $sformatf("%h", led), $sformatf("%h", saved));
    check("pause_no_tick", n_ticks == t0, $sformatf("%0d ticks", n_ticks - t0), "0 ticks");
    check("pause_pending", pending === 1'b1, $sformatf("%b", pending), "1");
    repeat (3 * TD) cycle(2'd0, 1'b0, 1'b0);

    // Randomized requests and pauses
    repeat (400) cycle(2'($urandom_range(0, 3)), 1'($urandom_range(0, 15) == 0),
                       1'($urandom_range(0, 7) == 0));

    // Asynchronous reset mid-frame with a request pending
    cycle(2'd1, 1'b1, 1'b0);
    cycle(2'd0, 1'b0, 1'b0);
    #2;
    rs = 1'b1;
    #1;
    check("arst_led", led === 8'h03, $sformatf("%h", led), "03");
    check("arst_mode", mode === 2'd0, $sformatf("%0d", mode), "0");
    check("arst_pending", pending === 1'b0, $sformatf("%b", pending), "0");
    @(posedge clk);
    #1;
    model_reset();
    rs = 1'b0;
    repeat (10 * TD) cycle(2'd0, 1'b0, 1'b0);

    @(negedge clk);
    #1;
    check("queue_drained", exp_q.size() == 0, $sformatf("%0d left", exp_q.size()), "0 left");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
